// File: rtl/sobol_fp16_multi.sv
// Multi-dimensional Sobol sequence generator. Each accepted point advances every
// dimension by one Gray-code step and presents x/2^WIDTH as truncated FP16 per dimension.
module sobol_fp16_multi #(
    parameter int NUM_DIM = 2,
    parameter int WIDTH   = 32,
    parameter int DW      = (NUM_DIM > 1) ? $clog2(NUM_DIM) : 1,
    parameter int BW      = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   cfg_we,
    input  logic [DW-1:0]          cfg_dim,
    input  logic [BW-1:0]          cfg_bit,
    input  logic [WIDTH-1:0]       cfg_data,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [16*NUM_DIM-1:0]  out_fp16,
    output logic [WIDTH-1:0]       out_index,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_reg, state_next;
    logic [WIDTH-1:0]      dir_reg [NUM_DIM][WIDTH];
    logic [WIDTH-1:0]      x_reg   [NUM_DIM];
    logic [WIDTH-1:0]      x_next  [NUM_DIM];
    logic [WIDTH-1:0]      index_reg;
    logic [16*NUM_DIM-1:0] fp16_reg, fp16_next;
    logic [BW-1:0]         flip_bit;
    logic                  transfer, last_point, cfg_ok;

    // Dim 0 is van der Corput; higher dims use the x+1 primitive polynomial.
    function automatic logic [WIDTH-1:0] default_dir(input int d, input int k);
        logic [WIDTH-1:0] v;
        v = '0;
        v[WIDTH-1] = 1'b1;
        if (d == 0)
            v = v >> k;
        else
            for (int i = 1; i <= k; i++) v = v ^ (v >> 1);
        return v;
    endfunction

    function automatic logic [BW-1:0] lowest_zero(input logic [WIDTH-1:0] n);
        logic [BW-1:0] c;
        c = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (!n[i]) c = BW'(i);
        return c;
    endfunction

    // Round-toward-zero conversion of x/2^WIDTH; subnormals keep floor(x*2^(24-WIDTH)).
    function automatic logic [15:0] to_fp16(input logic [WIDTH-1:0] x);
        int         p;
        logic [4:0] e;
        logic [9:0] m;
        logic [15:0] r;
        p = 0;
        for (int i = 0; i < WIDTH; i++)
            if (x[i]) p = i;
        e = 5'(p + 15 - WIDTH);
        r = 16'h0000;
        if (x != '0) begin
            if (p > WIDTH - 15) begin
                m = 10'(({x, 10'b0} << (WIDTH - 1 - p)) >> (WIDTH - 1));
                r = {1'b0, e, m};
            end else begin
                m = 10'({x, 24'b0} >> WIDTH);
                r = {6'b0, m};
            end
        end
        return r;
    endfunction

    assign transfer   = (state_reg == RUN) && out_ready;
    assign last_point = (index_reg == '1);
    assign cfg_ok     = cfg_we && ((state_reg == IDLE) || (state_reg == DONE));
    assign flip_bit   = lowest_zero(index_reg);

    // Out-of-range cfg_dim/cfg_bit match no register, so such writes fall away.
    for (genvar gi = 0; gi < NUM_DIM; gi++) begin : g_dim
        for (genvar gk = 0; gk < WIDTH; gk++) begin : g_bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    dir_reg[gi][gk] <= default_dir(gi, gk);
                else if (cfg_ok && (cfg_dim == DW'(gi)) && (cfg_bit == BW'(gk)))
                    dir_reg[gi][gk] <= cfg_data;
            end
        end
        assign x_next[gi]             = x_reg[gi] ^ dir_reg[gi][flip_bit];
        assign fp16_next[16*gi +: 16] = to_fp16(x_next[gi]);
    end

    always_comb begin
        state_next = state_reg;
        if (start)
            state_next = RUN;
        else if (transfer && last_point)
            state_next = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // The final transfer only changes state; the last point stays on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NUM_DIM; d++) x_reg[d] <= '0;
            index_reg <= '0;
            fp16_reg  <= '0;
        end else if (start) begin
            for (int d = 0; d < NUM_DIM; d++) x_reg[d] <= '0;
            index_reg <= '0;
            fp16_reg  <= '0;
        end else if (transfer && !last_point) begin
            for (int d = 0; d < NUM_DIM; d++) x_reg[d] <= x_next[d];
            index_reg <= index_reg + 1'b1;
            fp16_reg  <= fp16_next;
        end
    end

    assign out_valid = (state_reg == RUN);
    assign done      = (state_reg == DONE);
    assign out_fp16  = fp16_reg;
    assign out_index = index_reg;

endmodule

// File: tb/tb_sobol_fp16_multi.sv
// Directed bench: a 32-bit two-dimension instance for sequence/config/corner checks
// and an 8-bit three-dimension instance run to exhaustion.
module tb_sobol_fp16_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: WIDTH=32, NUM_DIM=2
    logic        a_rst_n, a_start, a_cfg_we, a_ready, a_valid, a_done;
    logic [0:0]  a_cfg_dim;
    logic [4:0]  a_cfg_bit;
    logic [31:0] a_cfg_data, a_fp16, a_index;

    // Instance B: WIDTH=8, NUM_DIM=3
    logic        b_rst_n, b_start, b_cfg_we, b_ready, b_valid, b_done;
    logic [1:0]  b_cfg_dim;
    logic [2:0]  b_cfg_bit;
    logic [7:0]  b_cfg_data, b_index;
    logic [47:0] b_fp16;

    sobol_fp16_multi #(.NUM_DIM(2), .WIDTH(32)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .cfg_we(a_cfg_we),
        .cfg_dim(a_cfg_dim), .cfg_bit(a_cfg_bit), .cfg_data(a_cfg_data),
        .out_ready(a_ready), .out_valid(a_valid), .out_fp16(a_fp16),
        .out_index(a_index), .done(a_done)
    );

    sobol_fp16_multi #(.NUM_DIM(3), .WIDTH(8)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .cfg_we(b_cfg_we),
        .cfg_dim(b_cfg_dim), .cfg_bit(b_cfg_bit), .cfg_data(b_cfg_data),
        .out_ready(b_ready), .out_valid(b_valid), .out_fp16(b_fp16),
        .out_index(b_index), .done(b_done)
    );

    typedef struct {
        logic        ready;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [31:0] idx;
    } vec_t;

    typedef struct {
        logic [31:0] v;
        logic [15:0] fp;
    } sub_t;

    vec_t tbl [10];
    sub_t stb [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic a_reset();
        a_rst_n = 1'b0; a_start = 1'b0; a_cfg_we = 1'b0; a_ready = 1'b0;
        a_cfg_dim = '0; a_cfg_bit = '0; a_cfg_data = '0;
        @(negedge clk);
        @(negedge clk);
        a_rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'h0000, 16'h0000, 32'd0};
        tbl[1] = '{1'b1, 16'h3800, 16'h3800, 32'd1};
        tbl[2] = '{1'b1, 16'h3A00, 16'h3400, 32'd2};
        tbl[3] = '{1'b0, 16'h3400, 16'h3A00, 32'd3};
        tbl[4] = '{1'b0, 16'h3400, 16'h3A00, 32'd3};
        tbl[5] = '{1'b1, 16'h3400, 16'h3A00, 32'd3};
        tbl[6] = '{1'b1, 16'h3600, 16'h3600, 32'd4};
        tbl[7] = '{1'b1, 16'h3B00, 16'h3B00, 32'd5};
        tbl[8] = '{1'b1, 16'h3900, 16'h3000, 32'd6};
        tbl[9] = '{1'b0, 16'h3000, 16'h3900, 32'd7};

        stb[0] = '{32'h0000_0001, 16'h0000};
        stb[1] = '{32'h0000_0100, 16'h0001};
        stb[2] = '{32'h0000_4000, 16'h0040};
        stb[3] = '{32'h8010_0000, 16'h3800};

        b_rst_n = 1'b0; b_start = 1'b0; b_cfg_we = 1'b0; b_ready = 1'b0;
        b_cfg_dim = '0; b_cfg_bit = '0; b_cfg_data = '0;
        a_reset();
        b_rst_n = 1'b1;

        check("reset_valid", 64'(a_valid), 64'd0);
        check("reset_fp16",  64'(a_fp16),  64'd0);
        check("reset_index", 64'(a_index), 64'd0);
        check("reset_done",  64'(a_done),  64'd0);

        // Default sequence with a 1,0,0,1 back-pressure pattern
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            $display("seq row %0d: idx=%0d d0=%h d1=%h valid=%0b", i, a_index, a_fp16[15:0], a_fp16[31:16], a_valid);
            check("seq_valid", 64'(a_valid), 64'd1);
            check("seq_d0",    64'(a_fp16[15:0]),  64'(tbl[i].d0));
            check("seq_d1",    64'(a_fp16[31:16]), 64'(tbl[i].d1));
            check("seq_index", 64'(a_index),       64'(tbl[i].idx));
            a_ready = tbl[i].ready;
            @(negedge clk);
        end

        // start while stalled, with a config write attempted in RUN
        a_cfg_we = 1'b1; a_cfg_dim = 1'b1; a_cfg_bit = 5'd0; a_cfg_data = 32'h4000_0000;
        a_start = 1'b1; a_ready = 1'b1;
        @(negedge clk);
        a_cfg_we = 1'b0; a_start = 1'b0;
        $display("stall start: idx=%0d d0=%h", a_index, a_fp16[15:0]);
        check("stall_start_index", 64'(a_index), 64'd0);
        check("stall_start_fp16",  64'(a_fp16),  64'd0);
        @(negedge clk);
        $display("run cfg: idx=%0d d1=%h", a_index, a_fp16[31:16]);
        check("run_cfg_index",   64'(a_index),        64'd1);
        check("run_cfg_ignored", 64'(a_fp16[31:16]), 64'h3800);

        // Asynchronous reset mid-run takes effect before the next edge
        @(posedge clk);
        #2 a_rst_n = 1'b0;
        #1;
        $display("async reset: valid=%0b idx=%0d", a_valid, a_index);
        check("async_rst_valid", 64'(a_valid), 64'd0);
        check("async_rst_index", 64'(a_index), 64'd0);
        check("async_rst_fp16",  64'(a_fp16),  64'd0);
        @(negedge clk);
        a_rst_n = 1'b1; a_ready = 1'b0;
        @(negedge clk);

        // Config write in IDLE, then run
        a_cfg_we = 1'b1; a_cfg_dim = 1'b1; a_cfg_bit = 5'd0; a_cfg_data = 32'h4000_0000;
        @(negedge clk);
        a_cfg_we = 1'b0; a_start = 1'b1; a_ready = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("idle_cfg_p0_index", 64'(a_index), 64'd0);
        @(negedge clk);
        $display("idle cfg: idx=%0d d0=%h d1=%h", a_index, a_fp16[15:0], a_fp16[31:16]);
        check("idle_cfg_d0", 64'(a_fp16[15:0]),  64'h3800);
        check("idle_cfg_d1", 64'(a_fp16[31:16]), 64'h3400);

        // Reset restores default directions
        a_reset();
        a_start = 1'b1; a_ready = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        $display("post reset: idx=%0d d1=%h", a_index, a_fp16[31:16]);
        check("reset_dir_default", 64'(a_fp16[31:16]), 64'h3800);

        // Subnormal and truncation, config written on the start cycle from IDLE
        for (int i = 0; i < 4; i++) begin
            a_reset();
            a_cfg_we = 1'b1; a_cfg_dim = 1'b0; a_cfg_bit = 5'd0; a_cfg_data = stb[i].v;
            a_start = 1'b1; a_ready = 1'b1;
            @(negedge clk);
            a_cfg_we = 1'b0; a_start = 1'b0;
            @(negedge clk);
            $display("conv v=%h: idx=%0d d0=%h", stb[i].v, a_index, a_fp16[15:0]);
            check("conv_index", 64'(a_index),       64'd1);
            check("conv_d0",    64'(a_fp16[15:0]),  64'(stb[i].fp));
        end

        // Instance B: out-of-range dim write, then run to exhaustion
        b_cfg_we = 1'b1; b_cfg_dim = 2'd3; b_cfg_bit = 3'd0; b_cfg_data = 8'h40;
        @(negedge clk);
        b_cfg_we = 1'b0; b_start = 1'b1; b_ready = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            $display("w8 point: idx=%0d valid=%0b d0=%h", b_index, b_valid, b_fp16[15:0]);
            check("w8_valid_index", {55'd0, b_valid, b_index}, {55'd0, 1'b1, 8'(i)});
            if (i == 1) begin
                check("w8_p1_d0", 64'(b_fp16[15:0]),  64'h3800);
                check("w8_p1_d2", 64'(b_fp16[47:32]), 64'h3800);
            end
            @(negedge clk);
        end
        $display("w8 end: idx=%0d valid=%0b done=%0b", b_index, b_valid, b_done);
        check("w8_end_valid", 64'(b_valid), 64'd0);
        check("w8_end_done",  64'(b_done),  64'd1);
        check("w8_end_index", 64'(b_index), 64'd255);
        @(negedge clk);
        check("w8_done_held", {62'd0, b_done, b_valid}, {62'd0, 1'b1, 1'b0});

        // Config honoured in DONE on the start cycle; restart at point 0
        b_cfg_we = 1'b1; b_cfg_dim = 2'd0; b_cfg_bit = 3'd0; b_cfg_data = 8'h40;
        b_start = 1'b1;
        @(negedge clk);
        b_cfg_we = 1'b0; b_start = 1'b0;
        $display("w8 restart: idx=%0d valid=%0b done=%0b", b_index, b_valid, b_done);
        check("w8_restart", {54'd0, b_done, b_valid, b_index}, {54'd0, 1'b0, 1'b1, 8'd0});
        @(negedge clk);
        $display("w8 done cfg: idx=%0d d0=%h", b_index, b_fp16[15:0]);
        check("w8_done_cfg_index", 64'(b_index),       64'd1);
        check("w8_done_cfg_d0",    64'(b_fp16[15:0]),  64'h3400);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
